id_ex_pipe_stage: RTL and testbench

- Parametrised decode-to-execute pipeline stage for the vector ASIP; replaces the fixed-width, always-enabled decode/execute register.
- Carries the operand vectors, immediate, destination address, opcode and the execute/memory control bundle through a valid/ready elastic handshake with a 2-entry skid buffer.
- Supports back-pressure (stall), synchronous flush (branch kill) and bubble accounting.
- Sits between the register-file read stage and the ALU/execute stage.

---
 rtl/id_ex_pkg.sv | 42 ++++
 rtl/id_ex_pipe_stage_skid.sv | 112 +++++++++++
 rtl/id_ex_pipe_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pkg
// Shared definitions for the decode-to-execute pipeline stage of the vector
// ASIP. This package holds:
//   - the default widths of the stage,
//   - the control bundle (ctrl_t),
//   - the full transported payload (payload_t) at those default widths,
//   - CTRL_NOP, the bundle that is presented while no instruction is valid.
// The stage itself rebuilds the same layouts from its own parameters, so a
// non-default configuration stays self-consistent.
// ---------------------------------------------------------------------------
package id_ex_pkg;

    localparam int LANES_DEF    = 3;
    localparam int LANE_W_DEF   = 16;
    localparam int DATA_W_DEF   = LANES_DEF * LANE_W_DEF;
    localparam int ADDR_W_DEF   = 4;
    localparam int OP_W_DEF     = 4;
    localparam int ALUCTL_W_DEF = 2;
    localparam int CNT_W_DEF    = 16;

    typedef struct packed {
        logic                    regWrite;
        logic                    aluSrc;
        logic                    PCSrc;
        logic                    memToReg;
        logic                    memWrite;
        logic [ALUCTL_W_DEF-1:0] aluControl;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] SrcA;
        logic [DATA_W_DEF-1:0] SrcB;
        logic [DATA_W_DEF-1:0] ExtImm;
        logic [ADDR_W_DEF-1:0] WA3E;
        logic [OP_W_DEF-1:0]   opcode;
        ctrl_t                 ctrl;
    } payload_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(7'b000_0000);

endpackage

// File: rtl/id_ex_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry valid/ready skid buffer with synchronous flush.
//   clk, rst           : clock, asynchronous active-low reset
//   flush              : drop every held entry and any same-cycle accept
//   in_valid/in_ready  : upstream handshake (in_ready is registered)
//   in_data            : payload to capture
//   out_valid/out_ready: downstream handshake, out_valid = main entry valid
//   out_data           : main entry payload (registered)
// When the main entry becomes invalid, the payload bits selected by
// BUBBLE_MASK are loaded from BUBBLE_FILL while all other bits keep their
// previous value. This lets the owner hold safe control values on bubbles
// without any combinational gating on the outputs.
// ---------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int           W           = 8,
    parameter logic [W-1:0] BUBBLE_MASK = '0,
    parameter logic [W-1:0] BUBBLE_FILL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_r;
    logic         skid_v_r;
    logic         in_ready_r;
    logic [W-1:0] main_d_r;
    logic [W-1:0] skid_d_r;

    logic         accept_s;
    logic         main_free_s;
    logic         main_v_nxt_s;
    logic         skid_v_nxt_s;
    logic [W-1:0] main_d_sel_s;
    logic [W-1:0] main_d_nxt_s;
    logic [W-1:0] skid_d_nxt_s;

    // Next-state selection for main/skid entries; the skid entry always
    // drains into main before any newer input, keeping strict FIFO order.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        main_free_s  = ~main_v_r | out_ready;
        main_v_nxt_s = main_v_r;
        skid_v_nxt_s = skid_v_r;
        main_d_sel_s = main_d_r;
        skid_d_nxt_s = skid_d_r;
        if (flush) begin
            main_v_nxt_s = 1'b0;
            skid_v_nxt_s = 1'b0;
        end else if (main_free_s) begin
            if (skid_v_r) begin
                main_v_nxt_s = 1'b1;
                main_d_sel_s = skid_d_r;
                skid_v_nxt_s = accept_s;
                if (accept_s) begin
                    skid_d_nxt_s = in_data;
                end else begin
                    skid_d_nxt_s = skid_d_r;
                end
            end else begin
                main_v_nxt_s = accept_s;
                if (accept_s) begin
                    main_d_sel_s = in_data;
                end else begin
                    main_d_sel_s = main_d_r;
                end
            end
        end else begin
            // Main is stalled: a new accept can only land in the empty skid.
            if (accept_s) begin
                skid_v_nxt_s = 1'b1;
                skid_d_nxt_s = in_data;
            end else begin
                skid_v_nxt_s = skid_v_r;
            end
        end
        if (main_v_nxt_s) begin
            main_d_nxt_s = main_d_sel_s;
        end else begin
            main_d_nxt_s = (main_d_sel_s & ~BUBBLE_MASK) | (BUBBLE_FILL & BUBBLE_MASK);
        end
    end

    // Entry storage and registered ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_r   <= 1'b0;
            skid_v_r   <= 1'b0;
            main_d_r   <= '0;
            skid_d_r   <= '0;
            in_ready_r <= 1'b1;
        end else begin
            main_v_r   <= main_v_nxt_s;
            skid_v_r   <= skid_v_nxt_s;
            main_d_r   <= main_d_nxt_s;
            skid_d_r   <= skid_d_nxt_s;
            in_ready_r <= ~skid_v_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_r;
    assign out_data  = main_d_r;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_stage
// Decode-to-execute pipeline register for the vector ASIP with an elastic
// valid/ready handshake, 2-entry skid buffer, flush and bubble accounting.
//   clk, rst                : clock, asynchronous active-low reset
//   flush                   : synchronous kill of held and incoming work
//   in_valid / in_ready     : upstream handshake (in_ready registered)
//   rd1, rd2, extend        : operand vectors and extended immediate
//   ra3, opcode             : destination register and opcode
//   regWrite .. aluControl  : execute/memory control bundle
//   out_valid / out_ready   : downstream handshake
//   SrcA, SrcB, ExtImm, WA3E, opcodeE, *E : registered execute-side fields
//   bubble_cnt              : saturating count of idle cycles seen downstream
// While no instruction is valid the whole control bundle is held at all
// zeros from a register, so regWriteE/memWriteE/PCSrcE cannot glitch a
// write or branch. Operand fields keep their last values.
// ---------------------------------------------------------------------------
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int ALUCTL_W = ALUCTL_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   rd1,
    input  logic [LANES*LANE_W-1:0]   rd2,
    input  logic [LANES*LANE_W-1:0]   extend,
    input  logic [ADDR_W-1:0]         ra3,
    input  logic [OP_W-1:0]           opcode,
    input  logic                      regWrite,
    input  logic                      aluSrc,
    input  logic                      PCSrc,
    input  logic                      memToReg,
    input  logic                      memWrite,
    input  logic [ALUCTL_W-1:0]       aluControl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   SrcA,
    output logic [LANES*LANE_W-1:0]   SrcB,
    output logic [LANES*LANE_W-1:0]   ExtImm,
    output logic [ADDR_W-1:0]         WA3E,
    output logic [OP_W-1:0]           opcodeE,
    output logic                      regWriteE,
    output logic                      aluSrcE,
    output logic                      PCSrcE,
    output logic                      memToRegE,
    output logic                      memWriteE,
    output logic [ALUCTL_W-1:0]       aluControlE,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int DATA_W = LANES * LANE_W;

    typedef struct packed {
        logic                regWrite;
        logic                aluSrc;
        logic                PCSrc;
        logic                memToReg;
        logic                memWrite;
        logic [ALUCTL_W-1:0] aluControl;
    } stage_ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] SrcA;
        logic [DATA_W-1:0] SrcB;
        logic [DATA_W-1:0] ExtImm;
        logic [ADDR_W-1:0] WA3E;
        logic [OP_W-1:0]   opcode;
        stage_ctrl_t       ctrl;
    } stage_payload_t;

    localparam int CTRL_W = $bits(stage_ctrl_t);
    localparam int PAY_W  = $bits(stage_payload_t);

    localparam stage_ctrl_t STAGE_CTRL_NOP = '0;

    // Only the control bundle is replaced on bubbles; the datapath holds.
    localparam logic [PAY_W-1:0] CTRL_MASK = {{(PAY_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};
    localparam logic [PAY_W-1:0] CTRL_FILL = {{(PAY_W-CTRL_W){1'b0}}, STAGE_CTRL_NOP};

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_payload_t   in_pay_s;
    stage_payload_t   main_pay_s;
    logic             out_valid_s;
    logic [CNT_W-1:0] bubble_cnt_r;

    assign in_pay_s = {rd1, rd2, extend, ra3, opcode,
                       regWrite, aluSrc, PCSrc, memToReg, memWrite, aluControl};

    pipe_skid_buf #(
        .W           (PAY_W),
        .BUBBLE_MASK (CTRL_MASK),
        .BUBBLE_FILL (CTRL_FILL)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (main_pay_s)
    );

    // Saturating count of cycles where execute was ready but got nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_r <= '0;
        end else if (!out_valid_s && out_ready && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign out_valid   = out_valid_s;
    assign SrcA        = main_pay_s.SrcA;
    assign SrcB        = main_pay_s.SrcB;
    assign ExtImm      = main_pay_s.ExtImm;
    assign WA3E        = main_pay_s.WA3E;
    assign opcodeE     = main_pay_s.opcode;
    assign regWriteE   = main_pay_s.ctrl.regWrite;
    assign aluSrcE     = main_pay_s.ctrl.aluSrc;
    assign PCSrcE      = main_pay_s.ctrl.PCSrc;
    assign memToRegE   = main_pay_s.ctrl.memToReg;
    assign memWriteE   = main_pay_s.ctrl.memWrite;
    assign aluControlE = main_pay_s.ctrl.aluControl;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_stage
// Scoreboard bench for id_ex_pipe_stage. Accepted instructions are queued
// at the handshake and compared when they reach the execute side. A second
// instance with a 4-bit bubble counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_stage;
    import id_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [47:0] rd1, rd2, extend;
    logic [3:0]  ra3, opcode;
    logic        regWrite, aluSrc, PCSrc, memToReg, memWrite;
    logic [1:0]  aluControl;

    logic        in_ready, out_valid;
    logic [47:0] SrcA, SrcB, ExtImm;
    logic [3:0]  WA3E, opcodeE;
    logic        regWriteE, aluSrcE, PCSrcE, memToRegE, memWriteE;
    logic [1:0]  aluControlE;
    logic [15:0] bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [47:0] s_SrcA, s_SrcB, s_ExtImm;
    logic [3:0]  s_WA3E, s_opcodeE;
    logic        s_regWriteE, s_aluSrcE, s_PCSrcE, s_memToRegE, s_memWriteE;
    logic [1:0]  s_aluControlE;
    logic [3:0]  s_bubble_cnt;

    payload_t    sb[$];
    payload_t    cur_p;
    logic [15:0] bcnt;
    logic [3:0]  bcnt4;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd1(rd1), .rd2(rd2), .extend(extend), .ra3(ra3), .opcode(opcode),
        .regWrite(regWrite), .aluSrc(aluSrc), .PCSrc(PCSrc), .memToReg(memToReg),
        .memWrite(memWrite), .aluControl(aluControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ExtImm(ExtImm), .WA3E(WA3E), .opcodeE(opcodeE),
        .regWriteE(regWriteE), .aluSrcE(aluSrcE), .PCSrcE(PCSrcE), .memToRegE(memToRegE),
        .memWriteE(memWriteE), .aluControlE(aluControlE), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .rd1(rd1), .rd2(rd2), .extend(extend), .ra3(ra3), .opcode(opcode),
        .regWrite(regWrite), .aluSrc(aluSrc), .PCSrc(PCSrc), .memToReg(memToReg),
        .memWrite(memWrite), .aluControl(aluControl),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .SrcA(s_SrcA), .SrcB(s_SrcB), .ExtImm(s_ExtImm), .WA3E(s_WA3E), .opcodeE(s_opcodeE),
        .regWriteE(s_regWriteE), .aluSrcE(s_aluSrcE), .PCSrcE(s_PCSrcE), .memToRegE(s_memToRegE),
        .memWriteE(s_memWriteE), .aluControlE(s_aluControlE), .bubble_cnt(s_bubble_cnt)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic payload_t mk(input int unsigned k);
        payload_t p;
        p.SrcA   = 48'h0001_0002_0003 + 48'(k);
        p.SrcB   = {16'($urandom), 32'($urandom)};
        p.ExtImm = {16'($urandom), 32'($urandom)};
        p.WA3E   = 4'($urandom);
        p.opcode = 4'($urandom);
        p.ctrl   = ctrl_t'(7'($urandom));
        return p;
    endfunction

    function automatic payload_t obs();
        payload_t p;
        p.SrcA            = SrcA;
        p.SrcB            = SrcB;
        p.ExtImm          = ExtImm;
        p.WA3E            = WA3E;
        p.opcode          = opcodeE;
        p.ctrl.regWrite   = regWriteE;
        p.ctrl.aluSrc     = aluSrcE;
        p.ctrl.PCSrc      = PCSrcE;
        p.ctrl.memToReg   = memToRegE;
        p.ctrl.memWrite   = memWriteE;
        p.ctrl.aluControl = aluControlE;
        return p;
    endfunction

    task automatic drv(input payload_t p, input logic v);
        cur_p      = p;
        in_valid   = v;
        rd1        = p.SrcA;
        rd2        = p.SrcB;
        extend     = p.ExtImm;
        ra3        = p.WA3E;
        opcode     = p.opcode;
        regWrite   = p.ctrl.regWrite;
        aluSrc     = p.ctrl.aluSrc;
        PCSrc      = p.ctrl.PCSrc;
        memToReg   = p.ctrl.memToReg;
        memWrite   = p.ctrl.memWrite;
        aluControl = p.ctrl.aluControl;
    endtask

    // Called at posedge+1: checks at the falling edge, updates the model,
    // then advances past the next rising edge.
    task automatic tick();
        bit mv, mr;
        #4;
        mv = (sb.size() != 0);
        mr = (sb.size() < 2);
        check_eq("in_ready", in_ready, mr);
        check_eq("out_valid", out_valid, mv);
        if (mv) check_eq("payload", obs(), sb[0]);
        else    check_eq("bubble_ctrl", {regWriteE, memWriteE, PCSrcE}, 3'b000);
        check_eq("bubble_cnt", bubble_cnt, bcnt);
        check_eq("bubble_cnt4", s_bubble_cnt, bcnt4);
        if (mv && out_ready) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (in_valid && mr) sb.push_back(cur_p);
        if (!mv && out_ready) begin
            if (bcnt != 16'hFFFF) bcnt++;
            if (bcnt4 != 4'hF) bcnt4++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        payload_t p;
        int unsigned k;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drv(payload_t'(159'd0), 1'b0);
        bcnt = 16'd0; bcnt4 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("por_out_valid", out_valid, 1'b0);
        check_eq("por_in_ready", in_ready, 1'b1);
        check_eq("por_bubble_cnt", bubble_cnt, 16'd0);
        rst = 1'b1;

        // Idle with a ready consumer: bubbles accumulate.
        out_ready = 1'b1;
        repeat (3) tick();

        // Back-to-back streaming.
        for (int i = 0; i < 4; i++) begin
            drv(mk(i), 1'b1);
            tick();
        end
        drv(mk(9), 1'b0);
        repeat (2) tick();

        // Skid: A stalled in main, B lands in skid, then both drain in order.
        out_ready = 1'b0;
        drv(mk(16), 1'b1); tick();
        drv(mk(17), 1'b1); tick();
        drv(mk(18), 1'b0); repeat (2) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush with main=A, skid=B and C offered.
        out_ready = 1'b0;
        drv(mk(32), 1'b1); tick();
        drv(mk(33), 1'b1); tick();
        drv(mk(34), 1'b1); flush = 1'b1; tick();
        flush = 1'b0; drv(mk(35), 1'b0); tick();
        out_ready = 1'b1; repeat (2) tick();

        // Flush during a retire with an accept that must be dropped.
        drv(mk(40), 1'b1); tick();
        drv(mk(41), 1'b1); flush = 1'b1; tick();
        flush = 1'b0; drv(mk(42), 1'b0); repeat (2) tick();

        // Control bundle must fall to zero after a writing instruction.
        p = mk(48);
        p.ctrl.regWrite = 1'b1; p.ctrl.memWrite = 1'b1; p.ctrl.PCSrc = 1'b1;
        drv(p, 1'b1); tick();
        drv(mk(49), 1'b0); repeat (3) tick();

        // Random traffic with occasional flushes.
        k = 64;
        for (int i = 0; i < 300; i++) begin
            drv(mk(k), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            k++;
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset with an instruction held on the outputs.
        out_ready = 1'b0;
        drv(mk(500), 1'b1); tick();
        drv(mk(501), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_bubble_cnt", bubble_cnt, 16'd0);
        check_eq("rst_srca", SrcA, 48'd0);
        check_eq("rst_wa3e", WA3E, 4'd0);
        check_eq("rst_ctrl", {regWriteE, memWriteE, PCSrcE, aluSrcE, memToRegE}, 5'd0);
        sb.delete();
        bcnt = 16'd0; bcnt4 = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Saturation of the 4-bit counter after 20 idle cycles.
        out_ready = 1'b1;
        repeat (20) tick();
        check_eq("sat_cnt4", s_bubble_cnt, 4'd15);
        check_eq("cnt16_20", bubble_cnt, 16'd20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
